// File: rtl/group_scan_cmd_ctrl.sv
// group_scan_cmd_ctrl
// -------------------
// Scan-side command controller for the group scan memory/register interface.
// A command frame is shifted in serially. scan_update then issues it on the
// static_*_group_mux request bus, and scan_id_group_mux toggles to launch it.
// The request is held until a rising edge of static_ready_group_mux. After
// that the returned read data is latched so that scan_capture can snapshot it
// for scan-out.
//
// Frame layout, LSB first on the wire:
//   {[parity], wen, ren, addr[ADDR_W-1:0], wdata[DATA_W-1:0]}
// Capture word: {[parity], 0..., busy, err[1], err[0], rdata_lat[DATA_W-1:0]}
//
// Optional feature: define SCAN_CMD_PARITY_EN to add an even-parity MSB to the
// frame. The controller checks it on update and generates it on capture.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   scan_shift, scan_in       serial shift enable / data in (enters the MSB)
//   scan_out                  serial data out (shift register bit 0)
//   scan_capture              load the readback word; clears err after the snapshot
//   scan_update               issue the command held in the shift register
//   static_wen/ren/addr/wdata_group_mux   registered request bus
//   static_rdata_group_mux    returned read data
//   static_ready_group_mux    downstream completion (rising edge is used)
//   scan_id_group_mux         toggles once per issued command
//   busy                      command outstanding (FSM is in WAIT)
//   err                       sticky: [0] illegal/dropped command, [1] timeout
//
// Handshake: a command is outstanding from the cycle after issue until the
// cycle after a 0->1 transition of static_ready_group_mux is seen in WAIT. A
// ready level that is already high when the command issues does not count.
module group_scan_cmd_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_shift,
  input  logic              scan_in,
  output logic              scan_out,
  input  logic              scan_capture,
  input  logic              scan_update,
  output logic              static_wen_group_mux,
  output logic              static_ren_group_mux,
  output logic [ADDR_W-1:0] static_addr_group_mux,
  output logic [DATA_W-1:0] static_wdata_group_mux,
  input  logic [DATA_W-1:0] static_rdata_group_mux,
  input  logic              static_ready_group_mux,
  output logic              scan_id_group_mux,
  output logic              busy,
  output logic [1:0]        err
);

  localparam int FRAME_W = 2 + ADDR_W + DATA_W;
`ifdef SCAN_CMD_PARITY_EN
  localparam int SR_W = FRAME_W + 1;
`else
  localparam int SR_W = FRAME_W;
`endif
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The counter holds the number of WAIT cycles already spent. The abort fires
  // on the TIMEOUT-th WAIT cycle, so WAIT lasts at most TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic                wen_q, wen_d, ren_q, ren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_lat_q, rdata_lat_d;
  logic                id_q, id_d;
  logic [1:0]          err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                prev_ready_q;

  // Frame decode and event qualification.
  logic                f_wen, f_ren, parity_ok;
  logic                upd_issue, upd_err, ready_edge, done, tout;
  logic [SR_W-1:0]     cap_word;

  assign f_wen = sr_q[FRAME_W-1];
  assign f_ren = sr_q[FRAME_W-2];
`ifdef SCAN_CMD_PARITY_EN
  assign parity_ok = ~(^sr_q);
`else
  assign parity_ok = 1'b1;
`endif

  assign ready_edge = static_ready_group_mux & ~prev_ready_q;
  assign upd_issue  = scan_update & (state_q == IDLE) & parity_ok & (f_wen ^ f_ren);
  assign upd_err    = scan_update & ((state_q == WAIT) | ~parity_ok | (f_wen & f_ren));
  assign done       = (state_q == WAIT) & ready_edge;
  // A ready edge in the same cycle as the last WAIT cycle wins over timeout.
  assign tout       = (state_q == WAIT) & ~ready_edge & (cnt_q == CNT_LAST);

  always_comb begin
    cap_word = '0;
    cap_word[DATA_W-1:0] = rdata_lat_q;
    cap_word[DATA_W]     = err_q[0];
    cap_word[DATA_W+1]   = err_q[1];
    cap_word[DATA_W+2]   = busy;
`ifdef SCAN_CMD_PARITY_EN
    cap_word[SR_W-1]     = ^cap_word[FRAME_W-1:0];
`endif
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (upd_issue)   state_d = WAIT;
      WAIT:    if (done | tout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    busy = (state_q == WAIT);
  end

  // Datapath next-state.
  always_comb begin
    sr_d        = sr_q;
    wen_d       = wen_q;
    ren_d       = ren_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_lat_d = rdata_lat_q;
    id_d        = id_q ^ upd_issue;
    cnt_d       = cnt_q;
    // Clear-on-read: the capture word above already holds the old err value.
    err_d       = scan_capture ? 2'b00 : err_q;

    if (scan_capture)    sr_d = cap_word;
    else if (scan_shift) sr_d = {scan_in, sr_q[SR_W-1:1]};

    if (upd_issue) begin
      wen_d   = f_wen;
      ren_d   = f_ren;
      addr_d  = sr_q[DATA_W +: ADDR_W];
      wdata_d = sr_q[DATA_W-1:0];
      cnt_d   = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (done & ren_q) rdata_lat_d = static_rdata_group_mux;
    if (done | tout) begin
      wen_d = 1'b0;
      ren_d = 1'b0;
    end

    if (upd_err) err_d[0] = 1'b1;
    if (tout)    err_d[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q         <= '0;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_lat_q  <= '0;
      id_q         <= 1'b0;
      err_q        <= 2'b00;
      cnt_q        <= '0;
      prev_ready_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      wen_q        <= wen_d;
      ren_q        <= ren_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_lat_q  <= rdata_lat_d;
      id_q         <= id_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      prev_ready_q <= static_ready_group_mux;
    end
  end

  assign scan_out               = sr_q[0];
  assign static_wen_group_mux   = wen_q;
  assign static_ren_group_mux   = ren_q;
  assign static_addr_group_mux  = addr_q;
  assign static_wdata_group_mux = wdata_q;
  assign scan_id_group_mux      = id_q;
  assign err                    = err_q;

endmodule

// File: doc/group_scan_cmd_ctrl.md
Name: group_scan_cmd_ctrl

Overview:
- Upstream neighbour of the group scan memory/register interface.
- Deserializes a scan-shifted command frame into the static_*_group_mux request bus and toggles scan_id_group_mux to launch it.
- Holds the request stable until the downstream ready handshake completes, then latches the returned read data for scan-out.
- Adds busy tracking, illegal-command rejection and a timeout.

Parameters:
- ADDR_W, 20, static address width.
- DATA_W, 32, static data width.
- TIMEOUT, 255, max WAIT cycles before abort; counter width = $clog2(TIMEOUT+1).

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- scan_shift  input  1  shift enable; shift register moves one bit per clk while high.
- scan_in  input  1  serial data in; enters the frame MSB.
- scan_out  output  1  serial data out = shift_reg[0].
- scan_capture  input  1  loads readback word into shift_reg.
- scan_update  input  1  one-cycle pulse; issues the command held in shift_reg.
- static_wen_group_mux  output  1  write request.
- static_ren_group_mux  output  1  read request.
- static_addr_group_mux  output  ADDR_W  request address.
- static_wdata_group_mux  output  DATA_W  write data.
- static_rdata_group_mux  input  DATA_W  returned read data.
- static_ready_group_mux  input  1  downstream completion.
- scan_id_group_mux  output  1  toggles once per issued command.
- busy  output  1  command outstanding.
- err  output  2  sticky: [0] illegal/dropped command, [1] timeout.

Behaviour:
- Frame: shift_reg is FRAME_W = 2+ADDR_W+DATA_W bits (54 default), laid out {wen, ren, addr, wdata} with wdata in the LSBs. Shift: shift_reg <= {scan_in, shift_reg[FRAME_W-1:1]}.
- Reset: all outputs, shift_reg, latched rdata and err clear to 0; state IDLE.
- scan_capture and scan_shift in the same cycle: capture wins. Capture loads shift_reg[DATA_W-1:0]=rdata_lat, [DATA_W]=err[0], [DATA_W+1]=err[1], [DATA_W+2]=busy; all other bits 0.
- Shifting and capture are legal in any state. They never disturb the outstanding bus, because the bus is driven from separate output registers.
- FSM states: IDLE, WAIT.
- IDLE, scan_update=1, frame wen^ren=1:
  - Next cycle: static_wen/ren/addr/wdata loaded from the frame.
  - scan_id toggles, busy=1, timeout counter cleared, prev_ready sampled.
  - Go to WAIT.
- IDLE, scan_update with wen=ren=1: no issue, err[0] set. With wen=ren=0: NOP, no toggle, no error.
- WAIT, rising edge of static_ready_group_mux (ready=1 and prev_ready=0):
  - Next cycle: if ren, rdata_lat <= static_rdata_group_mux.
  - static_wen/ren deassert, busy=0, go to IDLE.
  - addr/wdata hold their last value.
- WAIT, counter reaches TIMEOUT: next cycle deassert wen/ren, busy=0, err[1] set, rdata_lat unchanged, go to IDLE.
- scan_update while in WAIT: dropped, err[0] set.
- Ready edge and timeout in the same cycle: ready wins, no timeout error.
- Latency: update at cycle N → bus valid and scan_id toggled at N+1. Ready edge at cycle M → rdata_lat and busy=0 at M+1.
- err bits clear only on rst, or on a scan_capture (clear-on-read after the snapshot).
- rst asserted mid-WAIT: bus drops next edge. scan_id returns to 0; downstream treats this as a possible toggle and must be reset alongside.

Optional Feature:
- Macro SCAN_CMD_PARITY_EN.
- Defined:
  - Frame gains one MSB even-parity bit over the remaining FRAME_W bits (FRAME_W+1 total).
  - On scan_update, a parity mismatch sets err[0] and issues nothing.
  - Capture places parity of the captured word in the MSB.
- Undefined: no parity bit; frame is FRAME_W bits; no check.

Test Plan:
- Write: shift wen=1, ren=0, addr=0x00012, wdata=0xA5A5_0F0F, pulse update → at N+1 wen=1, addr=0x00012, wdata=0xA5A5_0F0F, scan_id 0→1, busy=1. Ready edge → busy=0 next cycle, wen=0.
- Read: frame ren=1, addr=0x00400; ready edge with rdata=0x1234_5678 → capture, then shift 32 bits out LSB-first; scan_out sequence = 0x1234_5678, busy bit=0.
- Illegal/NOP: frame wen=ren=1 → no toggle, err=2'b01. Frame wen=ren=0 → no toggle, err unchanged.
- Timeout: read with ready held 0 → after 255 WAIT cycles ren=0, busy=0, err[1]=1; capture shows bit DATA_W+1 set, then err clears.
- Busy drop and stale ready: update during WAIT → err[0]=1, scan_id toggles only once. Ready already high at issue → no completion until it falls and rises again.
- Parity (macro on): a frame with a flipped parity bit → no issue, err[0]=1; a correct frame issues normally.
